mc_control_ws: RTL and testbench
================================

Name: mc_control_ws

Overview:
- Next-generation multi-cycle MIPS32 control FSM. It drives the existing multi-cycle datapath: PC, IR, MDR, A/B, ALUOut, register file and a unified memory.
- Adds four things to the current controller:
  - a memory wait-state handshake (mem_ready) with a parametrised timeout;
  - BNE and JAL;
  - full R-type and I-type ALU decode;
  - a sticky TRAP state for illegal opcodes, illegal funcs and memory timeouts.

Parameters:
- ALUOP_W, 4: width of alu_op.
- MEM_WAIT_MAX, 15: number of consecutive mem_ready=0 cycles tolerated in one memory state before TRAP.
- TIMEOUT_EN, 1: 0 disables the timeout, so the FSM waits indefinitely.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  synchronous, active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag; sampled in EXE_BR.
- mem_ready  in  1  memory completes the access this cycle.
- ir_write, mdr_write, reg_write, a_write, b_write, alu_out_write  out  1  register load enables.
- reg_dst  out  2  register write address: 00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  register write data: 00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  3  000 B, 010 sign-extended imm, 011 sign-extended imm<<2, 100 const 4, 101 zero-extended imm.
- alu_op  out  ALUOP_W  ALU operation.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- pc_write, iord, mem_read, mem_write  out  1  PC load, address select, memory strobes.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- fault  out  1  sticky; high while in TRAP.
- state  out  4  current state, for debug.

Behaviour:
- One clock, clk. Reset is nrst, synchronous and active-low. At any rising edge with nrst=0: state<=IF, wait_cnt<=0; this overrides all other transitions, including mid-memory-access.
- Outputs are Moore decodes of state, qualified only by mem_ready, zero and op. Unlisted outputs default to 0; alu_op defaults to ADD.
- Reset output values, i.e. the IF decode: mem_read=1, iord=0, alu_src_a=0, alu_src_b=100, alu_op=ADD, pc_src=00. ir_write=pc_write=mem_ready. All other outputs are 0.
- States and transitions:
  - IF: hold until mem_ready=1, then go to ID. ir_write and pc_write are asserted only in the mem_ready cycle.
  - ID: a_write=b_write=alu_out_write=1, alu_src_b=011, ADD. Next state by op:
    - R-type → EXE_R.
    - ADDI/SLTI/ANDI/ORI/XORI → EXE_I.
    - BEQ/BNE → EXE_BR.
    - LW/SW → EXE_MEM.
    - J → EXE_J.
    - JAL → EXE_JAL.
    - any other op → TRAP.
  - EXE_R: alu_src_a=1, alu_src_b=000, alu_out_write=1, alu_op from func. Funcs: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL. An unknown func goes to TRAP (detected in ID, so EXE_R is never entered). Otherwise → WB_R.
  - EXE_I: alu_src_a=1, alu_out_write=1.
    - ADDI and SLTI: alu_src_b=010.
    - ANDI, ORI and XORI: alu_src_b=101.
    - alu_op matches the instruction.
    - Next state → WB_I.
  - EXE_BR: alu_src_a=1, alu_src_b=000, SUB, pc_src=01, pc_write=(zero XOR (op==BNE)), instr_done=1. Next state → IF.
  - EXE_MEM: alu_src_a=1, alu_src_b=010, ADD, alu_out_write=1. LW → MEM_LW, SW → MEM_SW.
  - EXE_J: pc_src=10, pc_write=1, instr_done=1. Next state → IF.
  - EXE_JAL: pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1. PC already holds PC+4. Next state → IF.
  - MEM_LW: iord=1, mem_read=1, mdr_write=mem_ready. Hold until mem_ready=1, then go to WB_LW.
  - MEM_SW: iord=1, mem_write=1. Hold until mem_ready=1, then go to IF; instr_done=mem_ready.
  - WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next state → IF.
  - WB_I: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next state → IF.
  - WB_LW: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next state → IF.
  - TRAP: all outputs 0 except fault=1. Stays in TRAP until reset; no further memory or register activity.
- Wait counter (applies in IF, MEM_LW and MEM_SW):
  - wait_cnt clears on entry to these states and whenever mem_ready=1.
  - Otherwise it increments each mem_ready=0 cycle, saturating.
  - If TIMEOUT_EN=1 and wait_cnt==MEM_WAIT_MAX with mem_ready=0 → TRAP.
  - mem_ready=1 in that same cycle completes normally.
  - The counter is wide enough to reach MEM_WAIT_MAX.
- Latency with zero wait states:
  - BEQ/BNE/J/JAL: 3 cycles.
  - R-type, I-type and SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait state adds one cycle.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode and func constants;
  - ALU op encodings (ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL);
  - state encodings;
  - alu_src_b, reg_dst, mem_to_reg and pc_src encodings.
- One sub-module, mc_alu_decode: combinational op/func → alu_op, alu_src_b and legal. It is used by ID (for the legality check) and by EXE_R/EXE_I.

Test Plan:
- nrst=0 for 2 edges mid-MEM_LW, then release → state=IF, mem_read=1, alu_src_b=100, mdr_write=0, fault=0.
- ADD with func=100000, mem_ready tied to 1 → sequence IF, ID, EXE_R, WB_R. reg_dst=01 and reg_write=1 in cycle 4; instr_done is high only in cycle 4.
- LW with mem_ready low for 3 cycles in MEM_LW → held 4 cycles; mdr_write high only in the 4th; total 8 cycles.
- BNE with zero=0 → pc_write=1, pc_src=01. Then BEQ with zero=0 → pc_write=0. Both take 3 cycles.
- JAL → in EXE_JAL: reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_src=10.
- Illegal op 111111 → TRAP after ID, fault=1 held through 10 cycles. Separately, IF with mem_ready=0 for 16 cycles (MEM_WAIT_MAX=15) → TRAP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller (mc_control_ws).
// Holds opcode/func constants, ALU operation codes, FSM state encoding,
// datapath mux select encodings and a helper that identifies the memory
// states in which the wait-state counter runs.
package mc_ctrl_pkg;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funcs, IR[5:0]
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operations; ADD is zero so an all-zero output word means "add"
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    // alu_src_b selects
    localparam logic [2:0] SRCB_B       = 3'b000;
    localparam logic [2:0] SRCB_SEXT    = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH = 3'b011;
    localparam logic [2:0] SRCB_FOUR    = 3'b100;
    localparam logic [2:0] SRCB_ZEXT    = 3'b101;

    // reg_dst selects
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // mem_to_reg selects
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // pc_src selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_EXE_BR  = 4'd4,
        S_EXE_MEM = 4'd5,
        S_EXE_J   = 4'd6,
        S_EXE_JAL = 4'd7,
        S_MEM_LW  = 4'd8,
        S_MEM_SW  = 4'd9,
        S_WB_R    = 4'd10,
        S_WB_I    = 4'd11,
        S_WB_LW   = 4'd12,
        S_TRAP    = 4'd13
    } state_e;

    // States that wait on mem_ready and run the wait counter
    function automatic logic is_mem_state(input state_e s);
        return (s == S_IF) || (s == S_MEM_LW) || (s == S_MEM_SW);
    endfunction

endpackage

// File: rtl/mc_control_ws_alu_decode.sv
// mc_alu_decode: combinational instruction decode.
//   op, func   : IR fields
//   alu_op     : ALU operation for EXE_R / EXE_I
//   alu_src_b  : ALU B-operand select for EXE_I (SRCB_B for R-type)
//   legal      : op (and func for R-type) is a supported instruction
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic [2:0] alu_src_b,
    output logic       legal
);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_B;
        legal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: legal  = 1'b0;
                endcase
            end
            // Arithmetic immediates are sign-extended, logical ones zero-extended
            OP_ADDI: begin alu_op = ALU_ADD; alu_src_b = SRCB_SEXT; end
            OP_SLTI: begin alu_op = ALU_SLT; alu_src_b = SRCB_SEXT; end
            OP_ANDI: begin alu_op = ALU_AND; alu_src_b = SRCB_ZEXT; end
            OP_ORI:  begin alu_op = ALU_OR;  alu_src_b = SRCB_ZEXT; end
            OP_XORI: begin alu_op = ALU_XOR; alu_src_b = SRCB_ZEXT; end
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            OP_LW, OP_SW: alu_src_b = SRCB_SEXT;
            OP_J, OP_JAL: ;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_ws.sv
// mc_control_ws: multi-cycle MIPS32 control FSM with memory wait states.
// Ports:
//   clk, nrst        : clock (rising edge), synchronous active-low reset
//   op, func, zero   : IR[31:26], IR[5:0], ALU zero flag (used in EXE_BR)
//   mem_ready        : memory completes the current access this cycle
//   *_write, reg_dst, mem_to_reg, alu_src_a/b, alu_op, pc_src, pc_write,
//   iord, mem_read, mem_write : datapath controls (Moore decode of state)
//   instr_done       : pulse in the final cycle of each instruction
//   fault            : high while in the sticky TRAP state
//   state            : current FSM state for debug
// Memory handshake: in IF/MEM_LW/MEM_SW the strobe (mem_read or mem_write)
// stays high every cycle; the access completes in the cycle mem_ready=1, and
// only then are the capturing enables (ir_write, pc_write, mdr_write) high.
// A run of MEM_WAIT_MAX+1 cycles with mem_ready=0 in one memory state
// traps when TIMEOUT_EN is set.
module mc_control_ws
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int TIMEOUT_EN   = 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               reg_write,
    output logic               a_write,
    output logic               b_write,
    output logic               alu_out_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               instr_done,
    output logic               fault,
    output logic [3:0]         state
);

    localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_e           cur, nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       dec_alu_op;
    logic [2:0]       dec_src_b;
    logic             dec_legal;
    logic             timeout;

    mc_alu_decode u_dec (
        .op        (op),
        .func      (func),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_src_b),
        .legal     (dec_legal)
    );

    assign timeout = (TIMEOUT_EN != 0) && !mem_ready &&
                     (wait_cnt == CNT_W'(MEM_WAIT_MAX));
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cur      <= S_IF;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            // Counting only while holding in a memory state also clears the
            // counter on every entry, since the previous cycle zeroed it.
            if (is_mem_state(cur) && (nxt == cur) && !mem_ready) begin
                if (wait_cnt != CNT_W'(MEM_WAIT_MAX))
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        nxt           = cur;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_W'(ALU_ADD);
        pc_src        = PCSRC_ALU;
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (cur)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)    nxt = S_ID;
                else if (timeout) nxt = S_TRAP;
            end
            S_ID: begin
                a_write       = 1'b1;
                b_write       = 1'b1;
                alu_out_write = 1'b1;   // speculative branch target
                alu_src_b     = SRCB_SEXT_SH;
                case (op)
                    OP_RTYPE:                                 nxt = S_EXE_R;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXE_I;
                    OP_BEQ, OP_BNE:                           nxt = S_EXE_BR;
                    OP_LW, OP_SW:                             nxt = S_EXE_MEM;
                    OP_J:                                     nxt = S_EXE_J;
                    OP_JAL:                                   nxt = S_EXE_JAL;
                    default:                                  nxt = S_TRAP;
                endcase
                // Illegal R-type funcs are caught here, before EXE_R
                if (!dec_legal) nxt = S_TRAP;
            end
            S_EXE_R: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                alu_op        = ALUOP_W'(dec_alu_op);
                nxt           = S_WB_R;
            end
            S_EXE_I: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                alu_src_b     = dec_src_b;
                alu_op        = ALUOP_W'(dec_alu_op);
                nxt           = S_WB_I;
            end
            S_EXE_BR: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_W'(ALU_SUB);
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero ^ (op == OP_BNE);
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_EXE_MEM: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_SEXT;
                alu_out_write = 1'b1;
                nxt           = (op == OP_SW) ? S_MEM_SW : S_MEM_LW;
            end
            S_EXE_J: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_EXE_JAL: begin
                // PC already holds PC+4, which is the link value
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_MEM_LW: begin
                iord      = 1'b1;
                mem_read  = 1'b1;
                mdr_write = mem_ready;
                if (mem_ready)    nxt = S_WB_LW;
                else if (timeout) nxt = S_TRAP;
            end
            S_MEM_SW: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)    nxt = S_IF;
                else if (timeout) nxt = S_TRAP;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
                nxt        = S_IF;
            end
            S_TRAP: begin
                fault = 1'b1;
            end
            default: nxt = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_control_ws.sv
// Directed bench for mc_control_ws. Each driven cycle queues the expected
// full control word; a negedge monitor pops and compares it.
module tb_mc_control_ws;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       ir_write, mdr_write, reg_write, a_write, b_write, alu_out_write;
    logic [1:0] reg_dst, mem_to_reg, pc_src;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic       pc_write, iord, mem_read, mem_write, instr_done, fault;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] state;
        logic       ir_write, mdr_write, reg_write, a_write, b_write, alu_out_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write, iord, mem_read, mem_write, instr_done, fault;
    } ctl_t;

    localparam int W = $bits(ctl_t);

    ctl_t         act;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mon_exp;
    string        mon_name;

    // clock / reset
    always #5 clk = ~clk;

    mc_control_ws #(.ALUOP_W(4), .MEM_WAIT_MAX(15), .TIMEOUT_EN(1)) dut (
        .clk(clk), .nrst(nrst), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .mdr_write(mdr_write),
        .reg_write(reg_write), .a_write(a_write), .b_write(b_write),
        .alu_out_write(alu_out_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .instr_done(instr_done), .fault(fault), .state(state)
    );

    assign act = {state, ir_write, mdr_write, reg_write, a_write, b_write,
                  alu_out_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_op, pc_src, pc_write, iord, mem_read, mem_write,
                  instr_done, fault};

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            n_cmp++;
            if (act !== mon_exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", mon_name, act, mon_exp);
            end
        end
    end

    // expected control words per state
    function automatic ctl_t base(input state_e s);
        ctl_t c = '0;
        c.state  = s;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

    function automatic ctl_t e_if(input logic r);
        ctl_t c = base(S_IF);
        c.mem_read = 1'b1; c.alu_src_b = 3'b100; c.ir_write = r; c.pc_write = r;
        return c;
    endfunction

    function automatic ctl_t e_id();
        ctl_t c = base(S_ID);
        c.a_write = 1'b1; c.b_write = 1'b1; c.alu_out_write = 1'b1; c.alu_src_b = 3'b011;
        return c;
    endfunction

    function automatic ctl_t e_exe(input state_e s, input logic [2:0] sb, input logic [3:0] aop);
        ctl_t c = base(s);
        c.alu_src_a = 1'b1; c.alu_out_write = 1'b1; c.alu_src_b = sb; c.alu_op = aop;
        return c;
    endfunction

    function automatic ctl_t e_br(input logic pcw);
        ctl_t c = base(S_EXE_BR);
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b01;
        c.pc_write = pcw; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_mem(input logic sw, input logic r);
        ctl_t c = base(sw ? S_MEM_SW : S_MEM_LW);
        c.iord = 1'b1;
        if (sw) begin c.mem_write = 1'b1; c.instr_done = r; end
        else    begin c.mem_read  = 1'b1; c.mdr_write  = r; end
        return c;
    endfunction

    function automatic ctl_t e_wb(input state_e s, input logic [1:0] rd, input logic [1:0] m2r);
        ctl_t c = base(s);
        c.reg_write = 1'b1; c.reg_dst = rd; c.mem_to_reg = m2r; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_jump(input logic link);
        ctl_t c = base(link ? S_EXE_JAL : S_EXE_J);
        c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
        if (link) begin c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
        return c;
    endfunction

    function automatic ctl_t e_trap();
        ctl_t c = '0;
        c.state = S_TRAP; c.fault = 1'b1;
        return c;
    endfunction

    // driver tasks
    task automatic cyc(input ctl_t e, input string nm, input logic r);
        mem_ready = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic fetch_decode(input string nm);
        cyc(e_if(1'b1), {nm, "_if"}, 1'b1);
        cyc(e_id(), {nm, "_id"}, 1'b1);
    endtask

    initial begin
        do_reset();

        // R-type ADD and SLT
        op = OP_RTYPE; func = 6'b100000;
        fetch_decode("add");
        cyc(e_exe(S_EXE_R, 3'b000, ALU_ADD), "add_exe", 1'b1);
        cyc(e_wb(S_WB_R, 2'b01, 2'b00), "add_wb", 1'b1);
        func = 6'b101010;
        fetch_decode("slt");
        cyc(e_exe(S_EXE_R, 3'b000, ALU_SLT), "slt_exe", 1'b1);
        cyc(e_wb(S_WB_R, 2'b01, 2'b00), "slt_wb", 1'b1);

        // I-type: ORI zero-extends, ADDI sign-extends
        op = 6'b001101;
        fetch_decode("ori");
        cyc(e_exe(S_EXE_I, 3'b101, ALU_OR), "ori_exe", 1'b1);
        cyc(e_wb(S_WB_I, 2'b00, 2'b00), "ori_wb", 1'b1);
        op = 6'b001000;
        fetch_decode("addi");
        cyc(e_exe(S_EXE_I, 3'b010, ALU_ADD), "addi_exe", 1'b1);
        cyc(e_wb(S_WB_I, 2'b00, 2'b00), "addi_wb", 1'b1);

        // LW with three wait states: 8 cycles
        op = 6'b100011;
        fetch_decode("lw");
        cyc(e_exe(S_EXE_MEM, 3'b010, ALU_ADD), "lw_exe", 1'b1);
        for (int i = 0; i < 3; i++) cyc(e_mem(1'b0, 1'b0), "lw_wait", 1'b0);
        cyc(e_mem(1'b0, 1'b1), "lw_mem", 1'b1);
        cyc(e_wb(S_WB_LW, 2'b00, 2'b01), "lw_wb", 1'b1);

        // SW, zero wait: 4 cycles
        op = 6'b101011;
        fetch_decode("sw");
        cyc(e_exe(S_EXE_MEM, 3'b010, ALU_ADD), "sw_exe", 1'b1);
        cyc(e_mem(1'b1, 1'b1), "sw_mem", 1'b1);

        // branches
        op = 6'b000101; zero = 1'b0;
        fetch_decode("bne");
        cyc(e_br(1'b1), "bne_z0", 1'b1);
        op = 6'b000100;
        fetch_decode("beq0");
        cyc(e_br(1'b0), "beq_z0", 1'b1);
        zero = 1'b1;
        fetch_decode("beq1");
        cyc(e_br(1'b1), "beq_z1", 1'b1);
        zero = 1'b0;

        // jumps
        op = 6'b000011;
        fetch_decode("jal");
        cyc(e_jump(1'b1), "jal_exe", 1'b1);
        op = 6'b000010;
        fetch_decode("j");
        cyc(e_jump(1'b0), "j_exe", 1'b1);

        // reset in the middle of a waiting MEM_LW
        op = 6'b100011;
        fetch_decode("rlw");
        cyc(e_exe(S_EXE_MEM, 3'b010, ALU_ADD), "rlw_exe", 1'b1);
        cyc(e_mem(1'b0, 1'b0), "rlw_wait", 1'b0);
        do_reset();
        cyc(e_if(1'b0), "rst_if", 1'b0);
        fetch_decode("lw2");
        cyc(e_exe(S_EXE_MEM, 3'b010, ALU_ADD), "lw2_exe", 1'b1);
        cyc(e_mem(1'b0, 1'b1), "lw2_mem", 1'b1);
        cyc(e_wb(S_WB_LW, 2'b00, 2'b01), "lw2_wb", 1'b1);

        // illegal func
        op = OP_RTYPE; func = 6'b111111;
        fetch_decode("badfn");
        for (int i = 0; i < 2; i++) cyc(e_trap(), "badfn_trap", 1'b1);
        do_reset();

        // illegal op, fault held for 10 cycles
        op = 6'b111111; func = 6'b100000;
        fetch_decode("badop");
        for (int i = 0; i < 10; i++) cyc(e_trap(), "badop_trap", 1'b1);
        do_reset();

        // 15 idle fetch cycles then ready on the limit cycle: no trap
        op = 6'b000010;
        for (int i = 0; i < 15; i++) cyc(e_if(1'b0), "edge_if_wait", 1'b0);
        cyc(e_if(1'b1), "edge_if_ready", 1'b1);
        cyc(e_id(), "edge_id", 1'b1);
        cyc(e_jump(1'b0), "edge_j", 1'b1);

        // 16 idle fetch cycles: timeout
        for (int i = 0; i < 16; i++) cyc(e_if(1'b0), "to_if_wait", 1'b0);
        for (int i = 0; i < 3; i++) cyc(e_trap(), "to_trap", 1'b1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
